// File: rtl/sram_multiport_ctrl_if.sv
// Requester-side bus of sram_multiport_ctrl: per-channel request/ack handshake,
// byte addresses, write bytes and the shared read byte.
interface sram_multiport_ctrl_if #(
  parameter int NUM_CH  = 2,
  parameter int SRAM_AW = 21
);
  logic [NUM_CH-1:0]             ch_req;
  logic [NUM_CH-1:0]             ch_we;
  logic [NUM_CH*(SRAM_AW+1)-1:0] ch_addr;
  logic [NUM_CH*8-1:0]           ch_wdata;
  logic [NUM_CH-1:0]             ch_ack;
  logic [7:0]                    ch_rdata;

  modport master (output ch_req, ch_we, ch_addr, ch_wdata, input ch_ack, ch_rdata);
  modport slave  (input ch_req, ch_we, ch_addr, ch_wdata, output ch_ack, ch_rdata);
endinterface

// File: rtl/sram_multiport_ctrl.sv
// Multi-channel byte-wide arbiter/controller for a 16-bit asynchronous SRAM.
// Define SRAM_ROUND_ROBIN_EN for round-robin arbitration; default is fixed priority.
module sram_multiport_ctrl #(
  parameter int NUM_CH      = 2,
  parameter int SRAM_AW     = 21,
  parameter int WAIT_STATES = 2
) (
  input  logic                 clk_chipset,
  input  logic                 reset,
  sram_multiport_ctrl_if.slave ch_bus,
  output logic [SRAM_AW-1:0]   sram_addr,
  inout  wire  [15:0]          sram_data,
  output logic                 sram_we_n,
  output logic                 sram_oe_n,
  output logic                 sram_ce_n,
  output logic                 sram_lb_n,
  output logic                 sram_ub_n
);
  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int CNT_W = $clog2(WAIT_STATES + 1);
  localparam int BA_W  = SRAM_AW + 1;

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, DONE} state_e;

  state_e             state_q;
  logic [IDX_W-1:0]   grant_q;
  logic [IDX_W-1:0]   grant_d;
  logic               any_req;
  logic               we_q;
  logic               lane_q;
  logic [CNT_W-1:0]   wait_q;
  logic [SRAM_AW-1:0] sram_addr_q;
  logic               we_n_q, oe_n_q, ce_n_q, lb_n_q, ub_n_q;
  logic               data_oe_q;
  logic [15:0]        data_out_q;
  logic [NUM_CH-1:0]  ack_q;
  logic [7:0]         rdata_q;
  logic [BA_W-1:0]    req_addr;
  logic               req_we;
  logic [7:0]         req_wdata;
  logic [7:0]         lane_byte;

`ifdef SRAM_ROUND_ROBIN_EN
  // rr_ptr_q holds the first channel to consider, i.e. last grant + 1.
  logic [IDX_W-1:0] rr_ptr_q;
  logic [IDX_W-1:0] rr_idx;

  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    grant_d = '0;
    any_req = 1'b0;
    rr_idx  = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      rr_idx = IDX_W'((int'(rr_ptr_q) + k) % NUM_CH);
      if (ch_bus.ch_req[rr_idx]) begin
        grant_d = rr_idx;
        any_req = 1'b1;
      end
    end
  end
`else
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    grant_d = '0;
    any_req = 1'b0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (ch_bus.ch_req[k]) begin
        grant_d = IDX_W'(k);
        any_req = 1'b1;
      end
    end
  end
`endif

  assign req_addr  = ch_bus.ch_addr[int'(grant_d)*BA_W +: BA_W];
  assign req_we    = ch_bus.ch_we[grant_d];
  assign req_wdata = ch_bus.ch_wdata[int'(grant_d)*8 +: 8];
  assign lane_byte = lane_q ? sram_data[15:8] : sram_data[7:0];

  // NOTE: all state below uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_chipset) begin
    if (reset) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      we_q        <= 1'b0;
      lane_q      <= 1'b0;
      wait_q      <= '0;
      sram_addr_q <= '0;
      we_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
      ce_n_q      <= 1'b1;
      lb_n_q      <= 1'b1;
      ub_n_q      <= 1'b1;
      data_oe_q   <= 1'b0;
      data_out_q  <= '0;
      ack_q       <= '0;
      rdata_q     <= '0;
`ifdef SRAM_ROUND_ROBIN_EN
      rr_ptr_q    <= '0;
`endif
    end else begin
      ack_q <= '0;
      case (state_q)
        IDLE: begin
          if (any_req) begin
            grant_q     <= grant_d;
            we_q        <= req_we;
            lane_q      <= req_addr[0];
            sram_addr_q <= req_addr[BA_W-1:1];
            ce_n_q      <= 1'b0;
            lb_n_q      <= req_addr[0];
            ub_n_q      <= ~req_addr[0];
            oe_n_q      <= req_we;
            data_oe_q   <= req_we;
            data_out_q  <= {req_wdata, req_wdata};
            wait_q      <= CNT_W'(WAIT_STATES - 1);
            state_q     <= SETUP;
`ifdef SRAM_ROUND_ROBIN_EN
            rr_ptr_q    <= (grant_d == IDX_W'(NUM_CH - 1)) ? '0 : grant_d + 1'b1;
`endif
          end
        end
        SETUP: begin
          we_n_q  <= ~we_q;
          state_q <= STROBE;
        end
        STROBE: begin
          if (wait_q == '0) begin
            we_n_q         <= 1'b1;
            ack_q[grant_q] <= 1'b1;
            if (!we_q) rdata_q <= lane_byte;
            state_q        <= DONE;
          end else begin
            wait_q <= wait_q - 1'b1;
          end
        end
        DONE: begin
          ce_n_q    <= 1'b1;
          oe_n_q    <= 1'b1;
          lb_n_q    <= 1'b1;
          ub_n_q    <= 1'b1;
          data_oe_q <= 1'b0;
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign sram_data       = data_oe_q ? data_out_q : 16'bz;
  assign sram_addr       = sram_addr_q;
  assign sram_we_n       = we_n_q;
  assign sram_oe_n       = oe_n_q;
  assign sram_ce_n       = ce_n_q;
  assign sram_lb_n       = lb_n_q;
  assign sram_ub_n       = ub_n_q;
  assign ch_bus.ch_ack   = ack_q;
  assign ch_bus.ch_rdata = rdata_q;
endmodule
